// File: rtl/tube_display_scheduler_if.sv
// tube_display_scheduler_if: source bus, board controls and digit-driver outputs of the tube scheduler
interface tube_display_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_SRC*32-1:0] Src_Data;
    logic [NUM_SRC-1:0]    Src_Valid;
    logic                  Btn_Next;
    logic                  Btn_Hold;
    logic                  Auto_En;
    logic [31:0]           Disp_Data;
    logic                  Disp_Sel;
    logic                  Scan_Tick;
    logic [IDX_W-1:0]      Cur_Src;
    logic                  Blank;

    modport master (
        output Src_Data, Src_Valid, Btn_Next, Btn_Hold, Auto_En,
        input  Disp_Data, Disp_Sel, Scan_Tick, Cur_Src, Blank
    );

    modport slave (
        input  Src_Data, Src_Valid, Btn_Next, Btn_Hold, Auto_En,
        output Disp_Data, Disp_Sel, Scan_Tick, Cur_Src, Blank
    );
endinterface

// File: rtl/tube_display_scheduler.sv
// tube_display_scheduler: time-shares one 4-digit tube between several 32-bit sources, one 16-bit half at a time
module tube_display_scheduler #(
    parameter int NUM_SRC     = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DWELL_TICKS = 2000,
    parameter int IDX_W       = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    tube_display_scheduler_if.slave  bus
);
    localparam int SCAN_W  = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DWELL_W = DWELL_TICKS > 1 ? $clog2(DWELL_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, SHOW_HI, SHOW_LO} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d, rr_idx, low_idx;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               tick_q, scan_wrap;
    logic [31:0]        data_q;
    logic               sel_q, blank_q;
    logic               any_valid, cur_ok, running, expiry;

    assign scan_wrap = scan_q == SCAN_W'(SCAN_DIV - 1);
    assign scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    assign any_valid = |bus.Src_Valid;
    assign cur_ok    = (int'(cur_q) < NUM_SRC) && bus.Src_Valid[cur_q];
    assign running   = (state_q != IDLE) && !bus.Btn_Hold && bus.Auto_En;
    assign expiry    = tick_q && running && (dwell_q == DWELL_W'(DWELL_TICKS - 1));

    // Round-robin successor of cur_q (itself if it is the only valid one) and lowest valid index
    always_comb begin
        rr_idx  = cur_q;
        low_idx = '0;
        for (int k = NUM_SRC; k >= 1; k--)
            if (bus.Src_Valid[(int'(cur_q) + k) % NUM_SRC]) rr_idx = IDX_W'((int'(cur_q) + k) % NUM_SRC);
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (bus.Src_Valid[k]) low_idx = IDX_W'(k);
    end

    // Page FSM: losing the shown source outranks expiry and Btn_Next, which merge into one advance
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        if (state_q == IDLE) begin
            if (any_valid) begin
                state_d = SHOW_HI;
                cur_d   = low_idx;
            end
        end else if (!any_valid) begin
            state_d = IDLE;
        end else if (!cur_ok) begin
            state_d = SHOW_HI;
            cur_d   = rr_idx;
        end else if (expiry || bus.Btn_Next) begin
            state_d = (state_q == SHOW_HI) ? SHOW_LO : SHOW_HI;
            cur_d   = (state_q == SHOW_HI) ? cur_q : rr_idx;
        end
        dwell_d = (state_d != state_q || cur_d != cur_q || expiry) ? '0 :
                  (running && tick_q) ? dwell_q + 1'b1 : dwell_q;
    end

    // State, counters and registered display outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cur_q   <= '0;
            scan_q  <= '0;
            tick_q  <= 1'b0;
            dwell_q <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            scan_q  <= scan_d;
            tick_q  <= scan_wrap;
            dwell_q <= dwell_d;
            data_q  <= (state_d == IDLE) ? '0 : bus.Src_Data[32*int'(cur_q) +: 32];
            sel_q   <= state_d == SHOW_LO;
            blank_q <= state_d == IDLE;
        end
    end

    assign bus.Disp_Data = data_q;
    assign bus.Disp_Sel  = sel_q;
    assign bus.Scan_Tick = tick_q;
    assign bus.Cur_Src   = cur_q;
    assign bus.Blank     = blank_q;
endmodule

// File: tb/tb_tube_display_scheduler.sv
// tb_tube_display_scheduler: vector table, directed corner sequences and random traffic against a behavioural model
module tb_tube_display_scheduler;
    localparam int NUM_SRC = 4;
    localparam int IDX_W   = 2;
    localparam int SDIV    = 4;
    localparam int DWELL   = 3;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    tube_display_scheduler_if #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) bus ();

    tube_display_scheduler #(
        .NUM_SRC(NUM_SRC), .SCAN_DIV(SDIV), .DWELL_TICKS(DWELL), .IDX_W(IDX_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Model of the displayed page: 0 = idle, 1 = high half, 2 = low half
    int          m_state, m_cur, m_dwell, m_scan;
    bit          m_tick, m_sel, m_blank;
    logic [31:0] m_data;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int rr_next(input int cur, input logic [3:0] v);
        for (int k = 1; k <= NUM_SRC; k++) if (v[(cur + k) % NUM_SRC]) return (cur + k) % NUM_SRC;
        return cur;
    endfunction

    task automatic model_step();
        bit run, exp;
        int ns, nc;
        logic [3:0] v;
        v = bus.Src_Valid;
        if (!RST_N) begin
            m_state = 0; m_cur = 0; m_dwell = 0; m_scan = 0;
            m_tick = 0; m_data = 0; m_sel = 0; m_blank = 1;
            return;
        end
        run = m_state != 0 && !bus.Btn_Hold && bus.Auto_En;
        exp = m_tick && run && m_dwell == DWELL - 1;
        ns = m_state;
        nc = m_cur;
        if (m_state == 0) begin
            if (v != 0) begin ns = 1; nc = lowest(v); end
        end else if (v == 0) begin
            ns = 0;
        end else if (!v[m_cur]) begin
            ns = 1; nc = rr_next(m_cur, v);
        end else if (exp || bus.Btn_Next) begin
            if (m_state == 1) ns = 2;
            else begin ns = 1; nc = rr_next(m_cur, v); end
        end
        m_data = (ns == 0) ? 32'd0 : bus.Src_Data[32*m_cur +: 32];
        if (ns != m_state || nc != m_cur || exp) m_dwell = 0;
        else if (run && m_tick) m_dwell++;
        m_tick = (m_scan == SDIV - 1);
        m_scan = (m_scan + 1) % SDIV;
        m_state = ns;
        m_cur = nc;
        m_sel = (ns == 2);
        m_blank = (ns == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit use_model);
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        if (use_model) begin
            chk("data", bus.Disp_Data, m_data);
            chk("sel", 32'(bus.Disp_Sel), 32'(m_sel));
            chk("tick", 32'(bus.Scan_Tick), 32'(m_tick));
            chk("cur", 32'(bus.Cur_Src), 32'(m_cur));
            chk("blank", 32'(bus.Blank), 32'(m_blank));
        end
    endtask

    task automatic run_until(input int src, input bit sel, input int max, input string name);
        int n;
        bit ok;
        n = 0;
        ok = bus.Cur_Src == IDX_W'(src) && bus.Disp_Sel == sel && !bus.Blank;
        while (!ok && n < max) begin
            cyc(1);
            n++;
            ok = bus.Cur_Src == IDX_W'(src) && bus.Disp_Sel == sel && !bus.Blank;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    typedef struct {
        bit          rst_n;
        logic [3:0]  valid;
        bit          nxt;
        logic [31:0] data;
        bit          sel;
        bit          tick;
        logic [1:0]  cur;
        bit          blank;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{0, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[1]  = '{0, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[2]  = '{0, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[3]  = '{1, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[4]  = '{1, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[5]  = '{1, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[6]  = '{1, 4'b0000, 0, 32'h0,         0, 1, 2'd0, 1};
        tbl[7]  = '{1, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[8]  = '{1, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[9]  = '{1, 4'b0000, 0, 32'h0,         0, 0, 2'd0, 1};
        tbl[10] = '{1, 4'b0000, 0, 32'h0,         0, 1, 2'd0, 1};
        tbl[11] = '{1, 4'b0101, 0, 32'h1234_5678, 0, 0, 2'd0, 0};
        tbl[12] = '{1, 4'b0101, 0, 32'h1234_5678, 0, 0, 2'd0, 0};
        tbl[13] = '{1, 4'b0101, 1, 32'h1234_5678, 1, 0, 2'd0, 0};
        tbl[14] = '{1, 4'b0101, 0, 32'h1234_5678, 1, 1, 2'd0, 0};

        bus.Src_Data  = {32'hC3C3_C3C3, 32'hDEAD_BEEF, 32'hA1A1_A1A1, 32'h1234_5678};
        bus.Src_Valid = 4'b0000;
        bus.Btn_Next  = 1'b0;
        bus.Btn_Hold  = 1'b0;
        bus.Auto_En   = 1'b1;

        for (int i = 0; i < 15; i++) begin
            RST_N         = tbl[i].rst_n;
            bus.Src_Valid = tbl[i].valid;
            bus.Btn_Next  = tbl[i].nxt;
            cyc(0);
            chk("tbl_data", bus.Disp_Data, tbl[i].data);
            chk("tbl_sel", 32'(bus.Disp_Sel), 32'(tbl[i].sel));
            chk("tbl_tick", 32'(bus.Scan_Tick), 32'(tbl[i].tick));
            chk("tbl_cur", 32'(bus.Cur_Src), 32'(tbl[i].cur));
            chk("tbl_blank", 32'(bus.Blank), 32'(tbl[i].blank));
        end
        bus.Btn_Next = 1'b0;

        run_until(2, 0, 200, "rot_reach_src2");
        cyc(1);
        chk("rot_src2_data", bus.Disp_Data, 32'hDEAD_BEEF);
        run_until(2, 1, 200, "rot_reach_src2_lo");
        run_until(0, 0, 200, "rot_back_src0");
        cyc(1);
        chk("rot_src0_data", bus.Disp_Data, 32'h1234_5678);

        bus.Btn_Hold = 1'b1;
        repeat (80) cyc(1);
        chk("hold_cur", 32'(bus.Cur_Src), 32'd0);
        chk("hold_sel", 32'(bus.Disp_Sel), 32'd0);
        bus.Btn_Next = 1'b1;
        cyc(1);
        bus.Btn_Next = 1'b0;
        chk("step_sel", 32'(bus.Disp_Sel), 32'd1);
        chk("step_cur", 32'(bus.Cur_Src), 32'd0);
        bus.Btn_Hold = 1'b0;

        begin
            int n;
            n = 0;
            while (!(m_tick && m_state == 2 && m_cur == 0 && m_dwell == DWELL - 1) && n < 100) begin
                cyc(1);
                n++;
            end
            chk("sim_found_expiry", 32'(n < 100), 32'd1);
        end
        bus.Btn_Next = 1'b1;
        cyc(1);
        bus.Btn_Next = 1'b0;
        chk("sim_cur", 32'(bus.Cur_Src), 32'd2);
        chk("sim_sel", 32'(bus.Disp_Sel), 32'd0);
        cyc(1);
        chk("sim_single_cur", 32'(bus.Cur_Src), 32'd2);
        chk("sim_single_sel", 32'(bus.Disp_Sel), 32'd0);

        bus.Src_Valid = 4'b0001;
        cyc(1);
        chk("drop_cur", 32'(bus.Cur_Src), 32'd0);
        chk("drop_sel", 32'(bus.Disp_Sel), 32'd0);
        chk("drop_blank", 32'(bus.Blank), 32'd0);
        bus.Src_Valid = 4'b0000;
        cyc(1);
        chk("idle_blank", 32'(bus.Blank), 32'd1);
        chk("idle_data", bus.Disp_Data, 32'd0);

        bus.Src_Valid = 4'b0101;
        run_until(2, 1, 200, "rst_reach_src2_lo");
        RST_N = 1'b0;
        cyc(1);
        chk("rst_blank", 32'(bus.Blank), 32'd1);
        chk("rst_cur", 32'(bus.Cur_Src), 32'd0);
        chk("rst_sel", 32'(bus.Disp_Sel), 32'd0);
        chk("rst_data", bus.Disp_Data, 32'd0);
        RST_N = 1'b1;
        bus.Src_Valid = 4'b0100;
        cyc(1);
        chk("rel_cur", 32'(bus.Cur_Src), 32'd2);
        chk("rel_sel", 32'(bus.Disp_Sel), 32'd0);
        chk("rel_blank", 32'(bus.Blank), 32'd0);

        repeat (3000) begin
            RST_N = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 15) == 0) bus.Src_Valid = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.Src_Data[32*$urandom_range(0, NUM_SRC-1) +: 32] = $urandom;
            bus.Btn_Next = ($urandom_range(0, 7) == 0);
            bus.Btn_Hold = ($urandom_range(0, 7) == 0);
            bus.Auto_En  = ($urandom_range(0, 9) != 0);
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
